// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shared multiply/divide engine for RV32/RV64.
// Shift-add multiply and restoring divide share one accumulator pair, retiring
// BITS_PER_CYCLE result bits per clock. Request and response use valid/ready
// handshakes, and abort discards any operation in flight.
// Optional build macro: MULDIV_SHORTCUT_EN. When it is defined, divide-by-zero,
// signed overflow and multiply by zero bypass CALC. Results are the same in
// both builds.
module muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            abort,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            busy
);

  localparam int N     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;

  logic [1:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       op_q;
  logic             sign_a_q, sign_b_q, div_zero_q;
  // acc_hi: product high half or partial remainder (one guard bit for the
  // restoring subtract). acc_lo: multiplier bits or dividend/quotient bits.
  logic [XLEN:0]    acc_hi_q;
  logic [XLEN-1:0]  acc_lo_q, mcand_q, result_q;

  logic             a_neg, b_neg, req_div_zero, req_ovf;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic [XLEN:0]    hi_nx, sum, trial;
  logic [XLEN-1:0]  lo_nx, quo, rem, fix_result;
  logic [2*XLEN-1:0] prod;

  assign req_ready   = (state_q == S_IDLE) && !abort;
  assign resp_valid  = (state_q == S_DONE);
  assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
  assign resp_result = result_q;

  // Operand conditioning: record signs and take magnitudes for signed ops.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    a_neg = 1'b0;
    b_neg = 1'b0;
    case (req_op)
      OP_MULH, OP_DIV, OP_REM: begin
        a_neg = req_a[XLEN-1];
        b_neg = req_b[XLEN-1];
      end
      OP_MULHSU: a_neg = req_a[XLEN-1];
      default: ;
    endcase
    a_mag        = a_neg ? -req_a : req_a;
    b_mag        = b_neg ? -req_b : req_b;
    req_div_zero = req_op[2] && (req_b == '0);
    req_ovf      = ((req_op == OP_DIV) || (req_op == OP_REM)) &&
                   (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (req_b == '1);
  end

  // One CALC iteration: BITS_PER_CYCLE shift-add or restoring-divide steps.
  always_comb begin
    hi_nx = acc_hi_q;
    lo_nx = acc_lo_q;
    sum   = '0;
    trial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (op_q[2]) begin
        hi_nx = {hi_nx[XLEN-1:0], lo_nx[XLEN-1]};
        trial = hi_nx - {1'b0, mcand_q};
        lo_nx = {lo_nx[XLEN-2:0], !trial[XLEN]};
        if (!trial[XLEN]) hi_nx = trial;
      end else begin
        sum   = {1'b0, hi_nx[XLEN-1:0]} +
                (lo_nx[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
        lo_nx = {sum[0], lo_nx[XLEN-1:1]};
        hi_nx = {1'b0, sum[XLEN:1]};
      end
    end
  end

  // Sign correction, special-case override and result selection.
  always_comb begin
    prod = {acc_hi_q[XLEN-1:0], acc_lo_q};
    if (sign_a_q ^ sign_b_q) prod = -prod;
    quo = acc_lo_q;
    if (sign_a_q ^ sign_b_q) quo = -quo;
    if (div_zero_q) quo = '1;
    rem = acc_hi_q[XLEN-1:0];
    if (sign_a_q) rem = -rem;
    case (op_q)
      OP_MUL:                     fix_result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:            fix_result = quo;
      default:                    fix_result = rem;
    endcase
  end

  // FSM and datapath registers; abort and reset both return to IDLE.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      mcand_q    <= '0;
      result_q   <= '0;
    end else if (abort) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid) begin
          op_q       <= req_op;
          sign_a_q   <= a_neg;
          sign_b_q   <= b_neg;
          div_zero_q <= req_div_zero;
          acc_hi_q   <= '0;
          acc_lo_q   <= a_mag;
          mcand_q    <= b_mag;
          if (!req_op[2]) begin
            acc_lo_q <= b_mag;
            mcand_q  <= a_mag;
          end
          state_q <= S_CALC;
          cnt_q   <= CNT_W'(N - 1);
`ifdef MULDIV_SHORTCUT_EN
          // Preload the accumulators with the final answer for special cases;
          // FIX is held two cycles so the result lands at a fixed E+2.
          if (req_div_zero || req_ovf ||
              (!req_op[2] && ((req_a == '0) || (req_b == '0)))) begin
            if (req_div_zero) acc_hi_q <= {1'b0, a_mag};
            if (!req_op[2]) acc_lo_q <= '0;
            state_q <= S_FIX;
            cnt_q   <= CNT_W'(1);
          end
`endif
        end
        S_CALC: begin
          acc_hi_q <= hi_nx;
          acc_lo_q <= lo_nx;
          if (cnt_q == '0) state_q <= S_FIX;
          else cnt_q <= cnt_q - CNT_W'(1);
        end
        S_FIX: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            result_q <= fix_result;
            state_q  <= S_DONE;
          end
        end
        default: if (resp_ready) state_q <= S_IDLE;
      endcase
    end
  end

  // Overflow needs no override: |MIN| / 1 negated is MIN and the remainder is 0.
  logic unused_ovf;
  assign unused_ovf = req_ovf;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an
// arithmetic reference model. Instance 0 runs BITS_PER_CYCLE=1, and instance 1
// runs BITS_PER_CYCLE=4.
module tb_muldiv_unit;

  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [2:0]  req_op [2];
  logic [31:0] req_a [2];
  logic [31:0] req_b [2];
  logic        abort [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_result [2];
  logic        busy [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u_bpc1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
    .req_a(req_a[0]), .req_b(req_b[0]), .abort(abort[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_result(resp_result[0]), .busy(busy[0])
  );

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u_bpc4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
    .req_a(req_a[1]), .req_b(req_b[1]), .abort(abort[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_result(resp_result[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension results from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    logic [31:0] r;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = p[63:32]; end
      3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = '1;
        else if (a == MIN && b == '1) r = MIN;
        else r = sa / sb;
      end
      3'd5: r = (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == MIN && b == '1) r = '0;
        else r = sa % sb;
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input int sel, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    int n;
    n = (sel == 0) ? 32 : 8;
`ifdef MULDIV_SHORTCUT_EN
    if ((op[2] && b == 0) || ((op == 3'd4 || op == 3'd6) && a == MIN && b == '1) ||
        (!op[2] && (a == 0 || b == 0)))
      return 2;
`endif
    return n + 1;
  endfunction

  // Present a request after the falling edge and let the next rising edge accept it.
  task automatic issue(input int sel, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    req_valid[sel] = 1'b1;
    req_op[sel]    = op;
    req_a[sel]     = a;
    req_b[sel]     = b;
    #1 check("req_ready_idle", req_ready[sel], 1'b1);
    @(posedge clk);
  endtask

  // Called right after the accept edge: measure latency, check result, stall, handshake.
  task automatic collect(input int sel, input string tag, input logic [31:0] exp,
                         input int lat_exp, input int stall);
    int lat;
    lat = 0;
    @(negedge clk);
    req_valid[sel] = 1'b0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) check({tag, "_busy"}, busy[sel], 1'b1);
    end while (!resp_valid[sel] && lat < 200);
    check({tag, "_latency"}, lat, lat_exp);
    check({tag, "_result"}, resp_result[sel], exp);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check({tag, "_stall_result"}, resp_result[sel], exp);
      check({tag, "_stall_valid"}, resp_valid[sel], 1'b1);
      check({tag, "_stall_ready"}, req_ready[sel], 1'b0);
    end
    @(negedge clk);
    resp_ready[sel] = 1'b1;
    @(posedge clk);
    #1 check({tag, "_valid_drop"}, resp_valid[sel], 1'b0);
    @(negedge clk);
    resp_ready[sel] = 1'b0;
  endtask

  task automatic run(input int sel, input string tag, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] b, input int stall);
    issue(sel, op, a, b);
    collect(sel, tag, ref_result(op, a, b), exp_lat(sel, op, a, b), stall);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return MIN;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_op[s] = '0; req_a[s] = '0; req_b[s] = '0;
      abort[s] = 1'b0; resp_ready[s] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check("rst_req_ready", req_ready[s], 1'b1);
      check("rst_resp_valid", resp_valid[s], 1'b0);
      check("rst_resp_result", resp_result[s], 32'h0);
      check("rst_busy", busy[s], 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Multiply: basic and high-half variants.
    run(0, "mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    check("mul_7x-3_model", ref_result(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    run(0, "mulh", 3'd1, MIN, 32'hFFFF_FFFF, 0);
    run(0, "mulhsu", 3'd2, MIN, 32'hFFFF_FFFF, 0);
    run(0, "mulhu", 3'd3, MIN, 32'hFFFF_FFFF, 1);

    // Divide special cases.
    run(0, "div_ovf", 3'd4, MIN, 32'hFFFF_FFFF, 0);
    run(0, "rem_ovf", 3'd6, MIN, 32'hFFFF_FFFF, 0);
    run(0, "divu_by0", 3'd5, 32'd5, 32'd0, 0);
    run(0, "rem_by0", 3'd6, 32'hFFFF_FFF7, 32'd0, 0);
    run(1, "div_by0_neg", 3'd4, 32'hFFFF_FFF7, 32'd0, 0);
    run(0, "mul_zero", 3'd1, 32'd0, 32'h1234_5678, 0);

    // Signed divide at 4 bits per cycle with a 5-cycle response stall.
    run(1, "div_-7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5);
    run(1, "rem_-7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5);

    // Abort a DIVU mid-flight while a new request is presented.
    issue(0, 3'd5, 32'hFFFF_0000, 32'd3);
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    abort[0]     = 1'b1;
    req_valid[0] = 1'b1;
    req_op[0]    = 3'd5;
    req_a[0]     = 32'd1000;
    req_b[0]     = 32'd7;
    #1 check("abort_req_ready", req_ready[0], 1'b0);
    @(posedge clk);
    #1;
    check("abort_busy", busy[0], 1'b0);
    check("abort_resp_valid", resp_valid[0], 1'b0);
    @(negedge clk);
    abort[0] = 1'b0;
    #1 check("post_abort_req_ready", req_ready[0], 1'b1);
    @(posedge clk);
    collect(0, "post_abort_divu", ref_result(3'd5, 32'd1000, 32'd7), 33, 0);

    // Synchronous reset mid-CALC with a request held valid.
    issue(0, 3'd0, 32'h1234_5678, 32'h0000_5678);
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst          = 1'b1;
    req_valid[0] = 1'b1;
    req_op[0]    = 3'd0;
    req_a[0]     = 32'h0001_0000;
    req_b[0]     = 32'h0001_0000;
    @(posedge clk);
    #1;
    check("midrst_req_ready", req_ready[0], 1'b1);
    check("midrst_resp_valid", resp_valid[0], 1'b0);
    check("midrst_resp_result", resp_result[0], 32'h0);
    check("midrst_busy", busy[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    collect(0, "post_rst_mul", 32'h0, 33, 0);
    run(0, "post_rst_mulhu", 3'd3, 32'h0001_0000, 32'h0001_0000, 0);
    check("post_rst_mulhu_model", ref_result(3'd3, 32'h0001_0000, 32'h0001_0000), 32'h1);

    // Random operations on both instances.
    for (int i = 0; i < 32; i++) begin
      int sel;
      logic [2:0] op;
      logic [31:0] a, b;
      sel = i % 2;
      op  = 3'($urandom_range(0, 7));
      a   = pick();
      b   = pick();
      run(sel, "rand", op, a, b, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
